// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - FIFO controller over a dual-port RAM (push on port A, pop on port B).
// Optional sticky error flags under `RAM_FIFO_ERR_EN.
module ram_fifo_ctrl #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [DATA_W-1:0] ram_dina,
  output logic              ram_web,
  output logic [ADDR_W-1:0] ram_addrb,
  output logic [DATA_W-1:0] ram_dinb,
  input  logic [DATA_W-1:0] ram_doutb
`ifdef RAM_FIFO_ERR_EN
  ,
  output logic              err_overflow,
  output logic              err_underflow
`endif
);

  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic            push_ok;
  logic            pop_ok;

  // The MSB of each pointer is a wrap bit, so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                   (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
  assign count   = wr_ptr - rd_ptr;

  assign push_ok = wr_en & ~full;
  assign pop_ok  = rd_en & ~empty;

  assign ram_wea   = push_ok & ~rst;
  assign ram_addra = wr_ptr[ADDR_W-1:0];
  assign ram_dina  = wr_data;
  assign ram_web   = 1'b0;
  assign ram_dinb  = '0;
  assign ram_addrb = rd_ptr[ADDR_W-1:0];

  // The RAM output register supplies the one cycle of pop latency.
  assign rd_data   = ram_doutb;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      rd_valid <= pop_ok;
    end
  end

`ifdef RAM_FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (wr_en & full)  err_overflow  <= 1'b1;
      if (rd_en & empty) err_underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb/tb_ram_fifo_ctrl.sv - scoreboard bench for ram_fifo_ctrl with a behavioural RAM and queue model.
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [3:0] wr_data;
  logic       full;
  logic       rd_en;
  logic [3:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic [2:0] count;
  logic       ram_wea;
  logic [1:0] ram_addra;
  logic [3:0] ram_dina;
  logic       ram_web;
  logic [1:0] ram_addrb;
  logic [3:0] ram_dinb;
  logic [3:0] ram_doutb;
`ifdef RAM_FIFO_ERR_EN
  logic       err_overflow;
  logic       err_underflow;
`endif

  ram_fifo_ctrl #(.DATA_W(4), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
    .count(count), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
    .ram_web(ram_web), .ram_addrb(ram_addrb), .ram_dinb(ram_dinb), .ram_doutb(ram_doutb)
`ifdef RAM_FIFO_ERR_EN
    , .err_overflow(err_overflow), .err_underflow(err_underflow)
`endif
  );

  always #5 clk = ~clk;

  // 4x4 RAM with registered port B read.
  logic [3:0] mem [4];
  always @(posedge clk) begin
    if (ram_wea) mem[ram_addra] <= ram_dina;
    ram_doutb <= mem[ram_addrb];
  end

  int total = 0;
  int bad = 0;
  bit started = 0;

  logic [3:0] mq[$];   // model FIFO contents
  logic [3:0] eq[$];   // data expected on rd_data this cycle
  int wn = 0, rn = 0;  // accepted pushes / pops since reset
  bit ovf = 0, unf = 0;
  bit p_rst = 1, p_push = 0, p_pop = 0, p_ovf = 0, p_unf = 0;
  logic [3:0] p_d = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input bit w, input logic [3:0] d, input bit r, input bit rs);
    int  cnt;
    bit  push_ok, pop_ok;
    @(posedge clk);
    if (p_rst) begin
      mq.delete(); wn = 0; rn = 0; ovf = 0; unf = 0;
    end else begin
      if (p_pop)  begin eq.push_back(mq.pop_front()); rn++; end
      if (p_push) begin mq.push_back(p_d); wn++; end
      if (p_ovf) ovf = 1;
      if (p_unf) unf = 1;
    end
    #1;
    wr_en = w; wr_data = d; rd_en = r; rst = rs;
    #1;
    cnt = mq.size();
    chk("count", 32'(count), 32'(cnt));
    chk("full", 32'(full), 32'(cnt == 4));
    chk("empty", 32'(empty), 32'(cnt == 0));
    chk("ram_addrb", 32'(ram_addrb), 32'(rn % 4));
    chk("ram_web", 32'(ram_web), 32'd0);
    chk("ram_dinb", 32'(ram_dinb), 32'd0);
`ifdef RAM_FIFO_ERR_EN
    chk("err_overflow", 32'(err_overflow), 32'(ovf));
    chk("err_underflow", 32'(err_underflow), 32'(unf));
`endif
    push_ok = w && (cnt < 4);
    pop_ok  = r && (cnt > 0);
    chk("ram_wea", 32'(ram_wea), 32'(push_ok && !rs));
    if (push_ok && !rs) begin
      chk("ram_addra", 32'(ram_addra), 32'(wn % 4));
      chk("ram_dina", 32'(ram_dina), 32'(d));
    end
    p_rst  = rs;
    p_push = push_ok && !rs;
    p_pop  = pop_ok && !rs;
    p_ovf  = w && (cnt == 4) && !rs;
    p_unf  = r && (cnt == 0) && !rs;
    p_d    = d;
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("rd_valid", 32'(rd_valid), 32'(eq.size() != 0));
      if (rd_valid && eq.size() != 0) chk("rd_data", 32'(rd_data), 32'(eq.pop_front()));
      else eq.delete();
    end
  end

  initial begin
    rst = 1; wr_en = 0; wr_data = '0; rd_en = 0;
    repeat (2) @(posedge clk);
    cyc(0, 4'h0, 0, 1);
    cyc(0, 4'h0, 0, 0);
    started = 1;
    // fill to full, then overflow attempt
    cyc(1, 4'hA, 0, 0);
    cyc(1, 4'hB, 0, 0);
    cyc(1, 4'hC, 0, 0);
    cyc(1, 4'hD, 0, 0);
    cyc(1, 4'h5, 0, 0);
    cyc(1, 4'h6, 1, 0);
    // drain back-to-back, then underflow attempts
    repeat (4) cyc(0, 4'h0, 1, 0);
    cyc(0, 4'h0, 1, 0);
    cyc(1, 4'h7, 1, 0);
    cyc(0, 4'h0, 1, 0);
    cyc(0, 4'h0, 0, 0);
    // wrap with simultaneous push+pop at count 2
    cyc(0, 4'h0, 0, 1);
    cyc(1, 4'h1, 0, 0);
    cyc(1, 4'h2, 0, 0);
    cyc(1, 4'h3, 0, 0);
    repeat (3) cyc(0, 4'h0, 1, 0);
    cyc(1, 4'h4, 0, 0);
    cyc(1, 4'h8, 0, 0);
    cyc(1, 4'h9, 1, 0);
    cyc(1, 4'hE, 1, 0);
    repeat (3) cyc(0, 4'h0, 1, 0);
    // reset right after a pop
    cyc(0, 4'h0, 0, 1);
    cyc(1, 4'h2, 0, 0);
    cyc(1, 4'h3, 0, 0);
    cyc(0, 4'h0, 1, 0);
    cyc(0, 4'h0, 0, 1);
    cyc(1, 4'hF, 0, 0);
    cyc(0, 4'h0, 1, 0);
    // randomized traffic with occasional reset
    for (int i = 0; i < 600; i++)
      cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 59) == 0));
    repeat (3) cyc(0, 4'h0, 0, 0);
    @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Synchronous FIFO controller that sits directly upstream of the 4x4 dual-port RAM and drives its two ports.
- Port A is used write-only for pushes. Port B is used read-only for pops; this block consumes doutb.
- Presents a push/pop interface with full/empty/count to the producer and consumer.
- Storage lives entirely in the RAM. This block holds only pointers, status and the read-return path.

Parameters:
- DATA_W, 4: data width; must match RAM dina/dinb/douta/doutb.
- ADDR_W, 2: RAM address width; DEPTH = 2**ADDR_W = 4 entries.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  push request.
- wr_data  in  DATA_W  push data.
- full  out  1  FIFO holds DEPTH entries.
- rd_en  in  1  pop request.
- rd_data  out  DATA_W  popped data; valid when rd_valid=1.
- rd_valid  out  1  one-cycle pulse, cycle after an accepted pop.
- empty  out  1  FIFO holds 0 entries.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- ram_wea  out  1  RAM port A write enable.
- ram_addra  out  ADDR_W  RAM port A address.
- ram_dina  out  DATA_W  RAM port A write data.
- ram_web  out  1  RAM port B write enable; constant 0.
- ram_addrb  out  ADDR_W  RAM port B address.
- ram_dinb  out  DATA_W  constant 0.
- ram_doutb  in  DATA_W  RAM port B read data; registered, valid 1 cycle after ram_addrb is sampled.

Behaviour:
- Pointers: wr_ptr and rd_ptr, each ADDR_W+1 bits.
  - RAM address = low ADDR_W bits.
  - MSB is the wrap bit; natural wrap 3 -> 0 toggles the MSB.
- empty = (wr_ptr == rd_ptr).
- full = low bits equal and MSBs differ.
- count = wr_ptr - rd_ptr, modulo 2**(ADDR_W+1).
- Accept rules (evaluated on registered state, same cycle):
  - push_ok = wr_en & ~full.
  - pop_ok = rd_en & ~empty.
- Push:
  - ram_wea = push_ok (combinational).
  - ram_addra = wr_ptr[ADDR_W-1:0].
  - ram_dina = wr_data.
  - wr_ptr increments at the clock edge.
- Pop:
  - ram_addrb = rd_ptr[ADDR_W-1:0], driven continuously.
  - On pop_ok, rd_ptr increments.
  - Next cycle: rd_valid=1 and rd_data = ram_doutb, passed combinationally from the RAM register.
  - Pop-to-data latency is exactly 1 cycle.
- Throughput: back-to-back pops are allowed, giving rd_valid on consecutive cycles.
- Simultaneous push and pop with neither full nor empty:
  - Both accepted; count unchanged.
  - Addresses always differ, so no RAM read-during-write collision.
- Push while full: rejected even if pop_ok in the same cycle. No RAM write, wr_ptr unchanged.
- Pop while empty: rejected even if push_ok in the same cycle. rd_valid=0 next cycle, rd_ptr unchanged.
- Rejected requests are dropped silently; there is no retry.
- rd_data when rd_valid=0: don't-care to consumers; the bench must not check it.
- Reset:
  - wr_ptr=0, rd_ptr=0, rd_valid=0, empty=1, full=0, count=0.
  - ram_wea=0 during any cycle in which rst=1.
  - Asserting rst mid-operation discards all contents and any in-flight pop.
  - rd_valid is 0 the cycle after the reset edge.
  - RAM contents are not cleared.

Optional Feature:
- Macro: RAM_FIFO_ERR_EN.
- Defined:
  - Adds outputs err_overflow (1) and err_underflow (1).
  - Both are sticky, set by a rejected push / rejected pop respectively.
  - Both cleared only by rst; reset value 0.
- Undefined: the ports and logic are absent; rejected requests leave no trace.

Test Plan:
- Reset, then push 0xA, 0xB, 0xC, 0xD on 4 consecutive cycles -> ram_addra 0,1,2,3 with ram_wea=1; count 1..4; full=1 after the 4th push.
- From full, push 0x5 -> ram_wea=0, count stays 4. With RAM_FIFO_ERR_EN, err_overflow=1 and stays set.
- 4 back-to-back pops -> rd_valid high 4 consecutive cycles, each one cycle after its pop; rd_data A, B, C, D; empty=1 afterwards.
- Pop while empty -> rd_valid=0 next cycle, rd_ptr unchanged. With RAM_FIFO_ERR_EN, err_underflow=1.
- Wrap and simultaneous: push 3, pop 3, push 3 (addresses 3, 0, 1) with a simultaneous push+pop at count=2 -> count stays 2; data order preserved across address wrap.
- Push 2 entries, pop 1, assert rst in the cycle after the pop -> rd_valid=0, empty=1, count=0; the next push goes to ram_addra=0.
